// File: rtl/led_pattern_ctrl.sv
// ----------------------------------------------------------------------------
// led_pattern_ctrl
//
// Purpose:
//   Host-programmable LED pattern sequencer. A small write-only register file,
//   loaded over a valid/ready command port, holds the mode, step period,
//   static value and run control. A one-hot FSM times each step with a
//   down-counter and produces the next 8-bit pattern. The open-drain LED
//   driver uses led_update in place of its own free-running timer.
//
// Ports:
//   CLK_50MHZ    in   1   system clock
//   RST          in   1   asynchronous active-low reset
//   cmd_valid    in   1   command present
//   cmd_ready    out  1   command accepted when cmd_valid && cmd_ready
//   cmd_addr     in   2   register select (0 mode, 1 period, 2 static, 3 ctrl)
//   cmd_data     in  24   write data
//   led_pattern  out  8   current pattern (1 = LED on)
//   led_update   out  1   one-cycle pulse, led_pattern changed this cycle
//   running      out  1   high whenever the FSM is not idle
//   cur_mode     out  4   active mode register
//
// State table:
//   state | meaning
//   IDLE  | stopped; waits for run or a single-step request
//   WAIT  | counting down the step period
//   STEP  | one cycle after a pattern update; commands stall here
// ----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter logic [23:0] TIMER_LOW_LIMIT = 24'h2625A0,
    parameter bit          RUN_AT_RESET    = 1'b1
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [23:0] cmd_data,
    output logic [7:0]  led_pattern,
    output logic        led_update,
    output logic        running,
    output logic [3:0]  cur_mode
);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_WAIT = 3'b010;
    localparam logic [2:0] S_STEP = 3'b100;

    localparam logic [3:0] MODE_RANDOM = 4'd1;
    localparam logic [3:0] MODE_ROTL   = 4'd2;
    localparam logic [3:0] MODE_ROTR   = 4'd3;
    localparam logic [3:0] MODE_UP     = 4'd4;
    localparam logic [3:0] MODE_DOWN   = 4'd5;
    localparam logic [3:0] MODE_STATIC = 4'd6;

    logic [2:0]  r_state;
    logic [23:0] r_cnt;
    logic [23:0] r_period;
    logic [7:0]  r_static;
    logic [3:0]  r_mode;
    logic        r_run;
    logic [7:0]  r_lfsr;
    logic        r_step_req;
    logic        r_pend;
    logic [1:0]  r_pend_addr;
    logic [23:0] r_pend_data;
    logic [7:0]  r_led_pattern;
    logic        r_led_update;

    logic [2:0]  w_next_state;
    logic        w_accept;
    logic        w_do_step;
    logic        w_cnt_load;
    logic        w_step_take;
    logic        w_step_set;
    logic [7:0]  w_lfsr_next;
    logic [7:0]  w_next_pattern;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Dropping run wins over an expiring count.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (r_run) begin
                    w_next_state = S_WAIT;
                end else if (r_step_req) begin
                    w_next_state = S_STEP;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!r_run) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == 24'd0) begin
                    w_next_state = S_STEP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_STEP: begin
                w_next_state = r_run ? S_WAIT : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode. The pattern register is loaded on the
    // edge that enters STEP, so the update pulse coincides with the STEP
    // cycle and cmd_ready drops in that same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready      = (r_state != S_STEP);
        running        = (r_state != S_IDLE);
        w_do_step      = (w_next_state == S_STEP);
        w_cnt_load     = (w_next_state == S_WAIT) && (r_state != S_WAIT);
        w_step_take    = (r_state == S_IDLE) && w_do_step;
        w_lfsr_next    = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        w_next_pattern = r_led_pattern;
        case (r_mode)
            MODE_RANDOM: w_next_pattern = w_lfsr_next;
            MODE_ROTL:   w_next_pattern = {r_led_pattern[6:0], r_led_pattern[7]};
            MODE_ROTR:   w_next_pattern = {r_led_pattern[0], r_led_pattern[7:1]};
            MODE_UP:     w_next_pattern = r_led_pattern + 8'd1;
            MODE_DOWN:   w_next_pattern = r_led_pattern - 8'd1;
            MODE_STATIC: w_next_pattern = r_static;
            default:     w_next_pattern = r_led_pattern;
        endcase
    end

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_step_set = r_pend && (r_pend_addr == 2'd3) && r_pend_data[1] && !r_pend_data[0];

    // ------------------------------------------------------------------
    // Command capture. Accepted writes are held one cycle and applied on
    // the following edge, so nothing on cmd_* reaches an output directly.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_pend      <= 1'b0;
            r_pend_addr <= 2'd0;
            r_pend_data <= 24'd0;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_pend_addr <= cmd_addr;
                r_pend_data <= cmd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_mode   <= MODE_ROTL;
            r_period <= TIMER_LOW_LIMIT;
            r_static <= 8'h00;
            r_run    <= RUN_AT_RESET;
        end else if (r_pend) begin
            case (r_pend_addr)
                2'd0: r_mode   <= r_pend_data[3:0];
                2'd1: r_period <= (r_pend_data < TIMER_LOW_LIMIT) ? TIMER_LOW_LIMIT : r_pend_data;
                2'd2: r_static <= r_pend_data[7:0];
                2'd3: r_run    <= r_pend_data[0];
                default: ;
            endcase
        end
    end

    // Single-step request stays armed until IDLE consumes it; any run=1
    // period discards it.
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_step_req <= 1'b0;
        end else if (w_step_set) begin
            r_step_req <= 1'b1;
        end else if (w_step_take || r_run) begin
            r_step_req <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Step timer: loaded with period-1 on entry to WAIT, terminal count 0.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_cnt <= 24'd0;
        end else if (w_cnt_load) begin
            r_cnt <= r_period - 24'd1;
        end else if ((r_state == S_WAIT) && (r_cnt != 24'd0)) begin
            r_cnt <= r_cnt - 24'd1;
        end
    end

    // ------------------------------------------------------------------
    // Pattern datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST) begin
        if (!RST) begin
            r_led_pattern <= 8'h01;
            r_led_update  <= 1'b0;
            r_lfsr        <= 8'h01;
        end else begin
            r_led_update <= w_do_step;
            if (w_do_step) begin
                r_led_pattern <= w_next_pattern;
            end
            if (w_do_step && (r_mode == MODE_RANDOM)) begin
                r_lfsr <= w_lfsr_next;
            end
        end
    end

    assign led_pattern = r_led_pattern;
    assign led_update  = r_led_update;
    assign cur_mode    = r_mode;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

    logic        CLK_50MHZ = 1'b0;
    logic        RST       = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_addr  = 2'd0;
    logic [23:0] cmd_data  = 24'd0;
    logic [7:0]  led_pattern;
    logic        led_update;
    logic        running;
    logic [3:0]  cur_mode;

    led_pattern_ctrl #(
        .TIMER_LOW_LIMIT(24'd4),
        .RUN_AT_RESET   (1'b1)
    ) dut (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .led_pattern(led_pattern),
        .led_update (led_update),
        .running    (running),
        .cur_mode   (cur_mode)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_upd = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [23:0] data;
        int          exp;
    } vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [23:0] data;
    } wr_t;

    vec_t tbl[17];
    wr_t  strm[12];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step_clk();
        @(posedge CLK_50MHZ);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [1:0] a, input logic [23:0] d);
        bit rdy;
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        do begin
            rdy = cmd_ready;
            step_clk();
            n++;
        end while (!rdy && n < 20);
        cmd_valid = 1'b0;
        if (!rdy) chk("send_timeout", int'(rdy), 1);
    endtask

    task automatic wait_update(input string name, input int exp_pat, input int gap);
        int         n;
        bit         seen;
        bit         stable;
        logic [7:0] prev;
        n      = 0;
        seen   = 1'b0;
        stable = 1'b1;
        prev   = led_pattern;
        while (!seen && n < 40) begin
            step_clk();
            n++;
            if (led_update) seen = 1'b1;
            else if (led_pattern != prev) stable = 1'b0;
        end
        chk({name, "_seen"}, int'(seen), 1);
        if (seen) begin
            chk({name, "_pat"}, int'(led_pattern), exp_pat);
            chk({name, "_stable"}, int'(stable), 1);
            if (gap > 0) chk({name, "_gap"}, cyc - last_upd, gap);
        end
        last_upd = cyc;
    endtask

    task automatic single_step(input string name, input int exp_pat);
        send(2'd3, 24'h000002);
        step_clk();
        chk({name, "_upd_n1"}, int'(led_update), 0);
        step_clk();
        chk({name, "_upd_n2"}, int'(led_update), 1);
        chk({name, "_pat"}, int'(led_pattern), exp_pat);
        step_clk();
        chk({name, "_idle"}, int'(running), 0);
    endtask

    // Reference step rules, written as plain arithmetic on integers.
    function automatic int lfsr_adv(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l * 2) % 256) + fb;
    endfunction

    function automatic int next_pat(input int mode, input int p, input int st, input int l_new);
        case (mode)
            1:       return l_new;
            2:       return ((p * 2) % 256) + (p / 128);
            3:       return (p / 2) + (p % 2) * 128;
            4:       return (p + 1) % 256;
            5:       return (p + 255) % 256;
            6:       return st;
            default: return p;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          pat;
        int          i;
        int          n;
        int          pend;
        int          exp_mode;
        int          rdy_bad;
        int          mode_bad;
        int          stalls;
        bit          rdy;
        int          op;
        logic [23:0] d;
        int          m_mode;
        int          m_p;
        int          m_st;
        int          m_l;
        int          e;

        tbl[0]  = '{2'd0, 24'h000002, 'h10};
        tbl[1]  = '{2'd0, 24'h000003, 'h08};
        tbl[2]  = '{2'd2, 24'h00003C, 'h04};
        tbl[3]  = '{2'd0, 24'h000006, 'h3C};
        tbl[4]  = '{2'd0, 24'h000004, 'h3D};
        tbl[5]  = '{2'd0, 24'h000005, 'h3C};
        tbl[6]  = '{2'd0, 24'h000000, 'h3C};
        tbl[7]  = '{2'd0, 24'h000009, 'h3C};
        tbl[8]  = '{2'd2, 24'h000080, 'h3C};
        tbl[9]  = '{2'd0, 24'hABCDE2, 'h78};
        tbl[10] = '{2'd0, 24'h000001, 'h11};
        tbl[11] = '{2'd0, 24'h000003, 'h88};
        tbl[12] = '{2'd2, 24'h0000FF, 'h44};
        tbl[13] = '{2'd0, 24'h000006, 'hFF};
        tbl[14] = '{2'd0, 24'h000004, 'h00};
        tbl[15] = '{2'd0, 24'h000005, 'hFF};
        tbl[16] = '{2'd1, 24'h000000, 'hFE};

        strm[0]  = '{2'd2, 24'h000011};
        strm[1]  = '{2'd0, 24'h000004};
        strm[2]  = '{2'd2, 24'h000022};
        strm[3]  = '{2'd0, 24'h000005};
        strm[4]  = '{2'd2, 24'h000033};
        strm[5]  = '{2'd0, 24'h000003};
        strm[6]  = '{2'd2, 24'h000044};
        strm[7]  = '{2'd0, 24'h000002};
        strm[8]  = '{2'd2, 24'h000055};
        strm[9]  = '{2'd0, 24'h000004};
        strm[10] = '{2'd2, 24'h0000A5};
        strm[11] = '{2'd0, 24'h000006};

        // Reset values
        #35;
        chk("rst_pattern", int'(led_pattern), 'h01);
        chk("rst_update",  int'(led_update), 0);
        chk("rst_ready",   int'(cmd_ready), 1);
        chk("rst_running", int'(running), 0);
        chk("rst_mode",    int'(cur_mode), 2);

        // Scenario 1: default rotate-left from release
        @(negedge CLK_50MHZ);
        RST = 1'b1;
        cyc = 0;
        last_upd = 0;
        pat = 1;
        for (int k = 0; k < 8; k++) begin
            pat = next_pat(2, pat, 0, 0);
            wait_update("s1", pat, 5);
        end

        // Scenario 2: mode=5, then period=10 mid-WAIT
        send(2'd0, 24'd5);
        send(2'd1, 24'd10);
        wait_update("s2_a", 'h00, 5);
        wait_update("s2_b", 'hFF, 11);
        wait_update("s2_c", 'hFE, 11);

        // Scenario 3: period below the limit is clamped
        send(2'd1, 24'd2);
        wait_update("s3_a", 'hFD, 11);
        wait_update("s3_b", 'hFC, 5);
        wait_update("s3_c", 'hFB, 5);

        // Scenario 4: stop, then single-step the LFSR
        send(2'd3, 24'd0);
        step_clk();
        step_clk();
        chk("s4_stopped", int'(running), 0);
        chk("s4_held",    int'(led_pattern), 'hFB);
        send(2'd0, 24'd1);
        single_step("s4_rnd1", 'h02);
        single_step("s4_rnd2", 'h04);
        single_step("s4_rnd3", 'h08);

        // Table-driven single-step vectors
        for (int t = 0; t < 17; t++) begin
            send(tbl[t].addr, tbl[t].data);
            single_step($sformatf("tbl%0d", t), tbl[t].exp);
        end

        // Scenario 5: back-to-back commands while running
        send(2'd3, 24'd1);
        i = 0; n = 0; pend = -1; exp_mode = 5;
        rdy_bad = 0; mode_bad = 0; stalls = 0;
        while (i < 12 && n < 100) begin
            cmd_valid = 1'b1;
            cmd_addr  = strm[i].addr;
            cmd_data  = strm[i].data;
            rdy = cmd_ready;
            if (rdy == led_update) rdy_bad++;
            if (!rdy) stalls++;
            step_clk();
            n++;
            if (pend >= 0) begin
                exp_mode = pend;
                pend = -1;
            end
            if (rdy) begin
                if (strm[i].addr == 2'd0) pend = int'(strm[i].data[3:0]);
                i++;
            end
            if (int'(cur_mode) != exp_mode) mode_bad++;
        end
        cmd_valid = 1'b0;
        step_clk();
        chk("s5_all_accepted", i, 12);
        chk("s5_ready_vs_step", rdy_bad, 0);
        chk("s5_mode_track", mode_bad, 0);
        chk("s5_stall_seen", int'(stalls > 0), 1);
        chk("s5_mode_final", int'(cur_mode), 6);
        wait_update("s5_static", 'hA5, -1);

        // Scenario 6: asynchronous reset in WAIT
        send(2'd2, 24'h00007F);
        step_clk();
        wait_update("s6_7f", 'h7F, -1);
        send(2'd0, 24'd4);
        send(2'd1, 24'd10);
        chk("s6_pre_mode", int'(cur_mode), 4);
        chk("s6_pre_pat",  int'(led_pattern), 'h7F);
        chk("s6_pre_run",  int'(running), 1);
        #2;
        RST = 1'b0;
        #1;
        chk("s6_rst_pattern", int'(led_pattern), 'h01);
        chk("s6_rst_update",  int'(led_update), 0);
        chk("s6_rst_ready",   int'(cmd_ready), 1);
        chk("s6_rst_running", int'(running), 0);
        chk("s6_rst_mode",    int'(cur_mode), 2);
        repeat (2) @(negedge CLK_50MHZ);
        RST = 1'b1;
        cyc = 0;
        last_upd = 0;
        wait_update("s6_r1", 'h02, 5);
        wait_update("s6_r2", 'h04, 5);
        wait_update("s6_r3", 'h08, 5);

        // Randomized single-step traffic against the reference model
        send(2'd3, 24'd0);
        step_clk();
        step_clk();
        chk("rnd_stopped", int'(running), 0);
        m_mode = 2; m_p = 'h08; m_st = 0; m_l = 1;
        for (int r = 0; r < 40; r++) begin
            op = $urandom_range(0, 5);
            d  = 24'($urandom);
            if (op == 0) begin
                send(2'd0, d);
                m_mode = int'(d[3:0]);
            end else if (op == 1) begin
                send(2'd2, d);
                m_st = int'(d[7:0]);
            end else if (op == 2) begin
                send(2'd1, d);
            end else begin
                if (m_mode == 1) m_l = lfsr_adv(m_l);
                e = next_pat(m_mode, m_p, m_st, m_l);
                m_p = e;
                single_step($sformatf("rnd%0d_m%0d", r, m_mode), e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
